// File: rtl/async_fifo_stream_reader_if.sv
// Bundles the async FIFO read port and the downstream valid/ready stream.
// out_last exists only when ASYNC_FIFO_READER_LAST_EN is defined.
interface async_fifo_stream_reader_if #(
  parameter int WIDTH     = 32,
  parameter int BUF_DEPTH = 2
);
  logic                               fifo_empty;
  logic [WIDTH-1:0]                   fifo_read_data;
  logic                               fifo_read_enable;
  logic [WIDTH-1:0]                   out_data;
  logic                               out_valid;
  logic                               out_ready;
  logic [$clog2(BUF_DEPTH+1)-1:0]     buf_level;
  logic [31:0]                        words_read;
`ifdef ASYNC_FIFO_READER_LAST_EN
  logic                               out_last;

  modport master (
    input  fifo_empty, fifo_read_data, out_ready,
    output fifo_read_enable, out_data, out_valid, buf_level, words_read, out_last
  );

  modport slave (
    output fifo_empty, fifo_read_data, out_ready,
    input  fifo_read_enable, out_data, out_valid, buf_level, words_read, out_last
  );
`else
  modport master (
    input  fifo_empty, fifo_read_data, out_ready,
    output fifo_read_enable, out_data, out_valid, buf_level, words_read
  );

  modport slave (
    output fifo_empty, fifo_read_data, out_ready,
    input  fifo_read_enable, out_data, out_valid, buf_level, words_read
  );
`endif
endinterface

// File: rtl/async_fifo_stream_reader.sv
// Drains an async FIFO read port into a small skid buffer and re-presents it as a valid/ready stream.
// Defining ASYNC_FIFO_READER_LAST_EN adds out_last marking every PKT_LEN-th word.
module async_fifo_stream_reader #(
  parameter int WIDTH     = 32,
  parameter int BUF_DEPTH = 2,
  parameter int PKT_LEN   = 16
) (
  input logic                          clk,
  input logic                          reset,
  async_fifo_stream_reader_if.master   bus
);
  localparam int LW = $clog2(BUF_DEPTH + 1);
  localparam int SW = $clog2(BUF_DEPTH + 2);
  localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam logic [PW-1:0] LAST_IDX = PW'(BUF_DEPTH - 1);
  localparam logic [SW-1:0] DEPTH_S  = SW'(BUF_DEPTH);

  logic [WIDTH-1:0] r_mem [BUF_DEPTH];
  logic [PW-1:0]    r_wrPtr;
  logic [PW-1:0]    r_rdPtr;
  logic [LW-1:0]    r_bufLevel;
  logic             r_inflight;
  logic [31:0]      r_wordsRead;

  logic             w_pop;
  logic [SW-1:0]    w_committed;
  logic             w_issue;

  // Slots already promised (held + in flight) net of this cycle's pop decide whether another read fits.
  assign w_pop       = (r_bufLevel != '0) && bus.out_ready;
  assign w_committed = SW'(r_bufLevel) + SW'(r_inflight) - SW'(w_pop);
  assign w_issue     = !reset && !bus.fifo_empty && (w_committed < DEPTH_S);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wrPtr     <= '0;
      r_rdPtr     <= '0;
      r_bufLevel  <= '0;
      r_inflight  <= 1'b0;
      r_wordsRead <= '0;
    end else begin
      if (r_inflight) begin
        r_mem[r_wrPtr] <= bus.fifo_read_data;
        r_wrPtr        <= (r_wrPtr == LAST_IDX) ? '0 : r_wrPtr + PW'(1);
      end
      if (w_pop) begin
        r_rdPtr     <= (r_rdPtr == LAST_IDX) ? '0 : r_rdPtr + PW'(1);
        r_wordsRead <= r_wordsRead + 32'd1;
      end
      r_inflight <= w_issue;
      r_bufLevel <= r_bufLevel + LW'(r_inflight) - LW'(w_pop);
    end
  end

  assign bus.fifo_read_enable = w_issue;
  assign bus.out_valid        = (r_bufLevel != '0);
  assign bus.out_data         = r_mem[r_rdPtr];
  assign bus.buf_level        = r_bufLevel;
  assign bus.words_read       = r_wordsRead;

`ifdef ASYNC_FIFO_READER_LAST_EN
  localparam int BW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(PKT_LEN - 1);

  logic [BW-1:0] r_beat;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_beat <= '0;
    end else if (w_pop) begin
      r_beat <= (r_beat == LAST_BEAT) ? '0 : r_beat + BW'(1);
    end
  end

  assign bus.out_last = (r_bufLevel != '0) && (r_beat == LAST_BEAT);
`endif
endmodule

// File: tb/tb_async_fifo_stream_reader.sv
// Randomised and directed bench for async_fifo_stream_reader against a queue-based model of the FIFO and stream.
// Out_last checks are active when ASYNC_FIFO_READER_LAST_EN is defined.
module tb_async_fifo_stream_reader;
  localparam int WIDTH     = 32;
  localparam int BUF_DEPTH = 2;
  localparam int PKT_LEN   = 4;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  async_fifo_stream_reader_if #(.WIDTH(WIDTH), .BUF_DEPTH(BUF_DEPTH)) bus ();

  async_fifo_stream_reader #(
    .WIDTH(WIDTH), .BUF_DEPTH(BUF_DEPTH), .PKT_LEN(PKT_LEN)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int          vecCount = 0;
  int          errCount = 0;
  int          stepNo = 0;
  int          grantCount = 0;
  int          lastCount = 0;
  logic [31:0] srcQ[$];
  logic [31:0] gQ[$];
  logic        inflightM, pendValid, prevHold, prevLast, sampledValid, sampledPop;
  logic [31:0] pendWord, prevData, popCount;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vecCount++;
    if (observed !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (step %0d)", tag, observed, expected, stepNo);
    end
  endtask

  task automatic clearModel();
    gQ.delete();
    inflightM = 1'b0;
    pendValid = 1'b0;
    prevHold  = 1'b0;
    prevLast  = 1'b0;
    popCount  = '0;
  endtask

  function automatic bit drained();
    return (srcQ.size() == 0) && (gQ.size() == 0);
  endfunction

  // One clock: drive at negedge, check settled outputs, then advance the model past the posedge.
  task automatic applyStimulus(input logic rdy, input logic srcOk);
    logic        pop, grant, expEn;
    int          expLevel;
    logic [31:0] w;
    @(negedge clk);
    bus.fifo_empty     = !(srcOk && (srcQ.size() != 0));
    bus.out_ready      = rdy;
    bus.fifo_read_data = pendValid ? pendWord : $urandom;
    #1;
    stepNo++;
    expLevel = gQ.size() - int'(inflightM);
    pop      = bus.out_valid && rdy;
    checkOutput("level", 32'(bus.buf_level), expLevel);
    checkOutput("valid", 32'(bus.out_valid), 32'(expLevel != 0));
    checkOutput("words", bus.words_read, popCount);
    expEn = !bus.fifo_empty && ((gQ.size() - int'(pop)) < BUF_DEPTH);
    checkOutput("rden", 32'(bus.fifo_read_enable), 32'(expEn));
    if (pop) checkOutput("data", bus.out_data, (gQ.size() != 0) ? gQ[0] : 32'hDEAD_BEEF);
    if (prevHold) begin
      checkOutput("hold_data", bus.out_data, prevData);
      checkOutput("hold_valid", 32'(bus.out_valid), 32'd1);
    end
`ifdef ASYNC_FIFO_READER_LAST_EN
    checkOutput("last", 32'(bus.out_last),
                32'((expLevel != 0) && ((popCount % PKT_LEN) == PKT_LEN - 1)));
    if (prevHold) checkOutput("hold_last", 32'(bus.out_last), 32'(prevLast));
    prevLast = bus.out_last;
    if (pop && bus.out_last) lastCount++;
`endif
    prevHold     = bus.out_valid && !rdy;
    prevData     = bus.out_data;
    sampledValid = bus.out_valid;
    sampledPop   = pop;
    grant        = bus.fifo_read_enable;
    @(posedge clk);
    if (pop && gQ.size() != 0) begin
      void'(gQ.pop_front());
      popCount++;
    end
    pendValid = 1'b0;
    inflightM = 1'b0;
    if (grant) grantCount++;
    if (grant && srcQ.size() != 0) begin
      w = srcQ.pop_front();
      gQ.push_back(w);
      pendValid = 1'b1;
      pendWord  = w;
      inflightM = 1'b1;
    end
  endtask

  task automatic applyReset(input int cycles);
    @(negedge clk);
    reset              = 1'b1;
    bus.fifo_empty     = 1'b1;
    bus.out_ready      = 1'b0;
    bus.fifo_read_data = $urandom;
    srcQ.delete();
    repeat (cycles) @(posedge clk);
    #1;
    checkOutput("rst_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("rst_rden", 32'(bus.fifo_read_enable), 32'd0);
    checkOutput("rst_level", 32'(bus.buf_level), 32'd0);
    checkOutput("rst_words", bus.words_read, 32'd0);
    checkOutput("rst_data", bus.out_data, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    clearModel();
  endtask

  int firstV, lastV, validCnt, startStep, stallCnt;

  initial begin
    reset              = 1'b1;
    bus.fifo_empty     = 1'b1;
    bus.out_ready      = 1'b0;
    bus.fifo_read_data = '0;
    clearModel();

    // Reset then idle.
    applyReset(3);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1);

    // Single word: first out_valid two cycles after fifo_empty falls.
    srcQ.push_back(32'hA5A5_0001);
    grantCount = 0;
    firstV     = -1;
    startStep  = stepNo + 1;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 1'b1);
      if (sampledValid && firstV < 0) firstV = stepNo;
    end
    #1;
    checkOutput("single_latency", 32'(firstV - startStep), 32'd2);
    checkOutput("single_rden_pulses", 32'(grantCount), 32'd1);
    checkOutput("single_words", bus.words_read, 32'd1);

    // Streaming 100 words with ready held high.
    applyReset(2);
    for (int i = 1; i <= 100; i++) srcQ.push_back(32'(i));
    firstV = -1; lastV = -1; validCnt = 0;
    for (int i = 0; i < 300 && !drained(); i++) begin
      applyStimulus(1'b1, 1'b1);
      if (sampledValid) begin
        if (firstV < 0) firstV = stepNo;
        lastV = stepNo;
        validCnt++;
      end
    end
    #1;
    checkOutput("stream_drained", 32'(drained()), 32'd1);
    checkOutput("stream_count", 32'(validCnt), 32'd100);
    checkOutput("stream_gapless", 32'(lastV - firstV + 1), 32'd100);
    checkOutput("stream_words", bus.words_read, 32'd100);

    // Backpressure: ready 3 low / 2 high.
    applyReset(2);
    for (int i = 1; i <= 20; i++) srcQ.push_back(32'(i));
    for (int i = 0; i < 200 && !drained(); i++) applyStimulus((i % 5) >= 3, 1'b1);
    #1;
    checkOutput("bp_drained", 32'(drained()), 32'd1);
    checkOutput("bp_words", bus.words_read, 32'd20);

    // Mid-operation reset with a held word and one in flight.
    applyReset(2);
    for (int i = 1; i <= 10; i++) srcQ.push_back(32'h100 + 32'(i));
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1);
    #1;
    checkOutput("pre_rst_level", 32'(bus.buf_level), 32'd1);
    checkOutput("pre_rst_inflight", 32'(pendValid), 32'd1);
    @(negedge clk);
    bus.fifo_read_data = pendWord;
    reset              = 1'b1;
    #1;
    checkOutput("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("mid_rst_level", 32'(bus.buf_level), 32'd0);
    checkOutput("mid_rst_words", bus.words_read, 32'd0);
    checkOutput("mid_rst_rden", 32'(bus.fifo_read_enable), 32'd0);
    @(negedge clk);
    bus.fifo_empty = 1'b1;
    bus.out_ready  = 1'b0;
    reset          = 1'b0;
    clearModel();
    for (int i = 0; i < 100 && !drained(); i++) applyStimulus(1'b1, 1'b1);
    #1;
    checkOutput("post_rst_drained", 32'(drained()), 32'd1);
    checkOutput("post_rst_words", bus.words_read, 32'd8);

    // Randomised source gaps and sink backpressure.
    applyReset(2);
    for (int i = 0; i < 60; i++) srcQ.push_back($urandom);
    for (int i = 0; i < 1500 && !(drained() && i >= 400); i++) begin
      if (i < 400 && $urandom_range(0, 7) == 0) srcQ.push_back($urandom);
      applyStimulus(1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0);
    end
    checkOutput("rand_drained", 32'(drained()), 32'd1);

`ifdef ASYNC_FIFO_READER_LAST_EN
    // Packet marking with a two-cycle stall on the fourth word.
    applyReset(2);
    for (int i = 1; i <= 8; i++) srcQ.push_back(32'h200 + 32'(i));
    lastCount = 0;
    stallCnt  = 0;
    for (int i = 0; i < 100 && !drained(); i++) begin
      logic rdy;
      rdy = !(popCount == 32'd3 && stallCnt < 2);
      applyStimulus(rdy, 1'b1);
      if (!rdy && sampledValid) stallCnt++;
    end
    checkOutput("last_drained", 32'(drained()), 32'd1);
    checkOutput("last_count", 32'(lastCount), 32'd2);
    checkOutput("last_stall", 32'(stallCnt), 32'd2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
